comparator_sampler: RTL

Synchronises, debounces and captures the outputs of up to `N_CH` on-die analog comparators in the user analog area, then reports the captured vector and a 2-bit status code on GPIO-mapped outputs. It replaces per-test firmware polling of comparator pads with a hardware measurement sequencer. Firmware starts a measurement, the block waits a programmable settle time, latches the debounced comparator vector and flags any instability seen during the settle window.

---
 rtl/comparator_sampler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/comparator_sampler.sv
// Comparator front end: per-channel synchroniser and debounce, plus a
// start/settle/capture sequencer that reports the captured vector and stability status.
module comparator_sampler #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 8,
  parameter int unsigned SETTLE_W    = 8
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic [N_CH-1:0]     comp_in,
  input  logic                start,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                ack,
  output logic [N_CH-1:0]     filt,
  output logic [N_CH-1:0]     result,
  output logic [N_CH-1:0]     changed,
  output logic                valid,
  output logic                busy,
  output logic [1:0]          status
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  logic [N_CH-1:0]     sync_q [SYNC_STAGES];
  logic [N_CH-1:0]     sync;
  logic [CW-1:0]       db_cnt_q [N_CH];
  logic [CW-1:0]       db_cnt_d [N_CH];
  logic [N_CH-1:0]     filt_q, filt_d;

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]     result_q, result_d;
  logic [N_CH-1:0]     changed_q, changed_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [1:0]          status_q, status_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= comp_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // The DEBOUNCE-th consecutive differing edge is the one that updates filt.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      db_cnt_d[i] = '0;
      if (sync[i] != filt_q[i]) begin
        if (db_cnt_q[i] == CW'(DEBOUNCE - 1)) filt_d[i] = sync[i];
        else                                 db_cnt_d[i] = db_cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) db_cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int unsigned i = 0; i < N_CH; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    changed_d = changed_q;
    valid_d   = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          cnt_d     = settle_cycles;
          changed_d = '0;
          result_d  = '0;
        end
      end
      ST_SETTLE: begin
        // filt_d vs filt_q flags a toggle on this very edge, capture edge included.
        changed_d = changed_q | (filt_q ^ filt_d);
        if (cnt_q == '0) begin
          result_d = filt_q;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end
      ST_DONE: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SETTLE);
    unique case (state_d)
      ST_SETTLE: status_d = 2'b01;
      ST_DONE:   status_d = (|changed_d) ? 2'b10 : 2'b11;
      default:   status_d = 2'b00;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      changed_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      status_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      changed_q <= changed_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      status_q  <= status_d;
    end
  end

  assign filt    = filt_q;
  assign result  = result_q;
  assign changed = changed_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign status  = status_q;

endmodule
